dino_sprite_line_fetcher: RTL and testbench

- Reader side of the dino/cactus sprite ROM: drives its address bus and captures its registered RGB565 output.
- During horizontal blanking it prefetches the next scanline's sprite row (SPR_W words) into an internal line buffer.
- During active video it emits a per-pixel colour/opaque flag to the VGA compositor.
- Sits between the VGA timing generator and the sprite ROM.

---
 rtl/dino_sprite_line_fetcher.sv | 155 +++++++++++++++
 tb/tb_dino_sprite_line_fetcher.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_sprite_line_fetcher.sv
// Sprite ROM reader: prefetches one sprite row per hblank into a line
// buffer, then streams per-pixel colour and opacity during active video.
module dino_sprite_line_fetcher #(
   parameter int          SPR_W      = 64,
   parameter int          SPR_H      = 32,
   parameter int          ADDR_W     = 12,
   parameter int          H_ACTIVE   = 640,
   parameter int          V_TOTAL    = 525,
   parameter logic [15:0] TRANSP_KEY = 16'hFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   input  logic              frame_start,
   input  logic              fetch_start,
   input  logic [10:0]       sprite_x,
   input  logic [9:0]        sprite_y,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [15:0]       pix_rgb,
   output logic              pix_valid,
   output logic              busy
);

   localparam int KW = $clog2(SPR_W + 1);
   localparam int IW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state, state_n;
   logic [KW-1:0]     k, k_n;
   logic [ADDR_W-1:0] addr_n, base;
   logic              busy_n;
   logic              row_valid, row_valid_n;
   logic [10:0]       pos_x;
   logic [9:0]        pos_y, py, tgt_line;
   logic [10:0]       row;
   logic              row_ok;
   logic              wr_en;
   logic [IW-1:0]     wr_idx;
   logic [15:0]       line_buf [SPR_W];
   logic [11:0]       hx, lo, hi;
   logic [IW-1:0]     idx;
   logic [15:0]       px;
   logic              hit;

   // Row selection; a coincident frame_start uses the fresh sprite_y.
   always_comb begin
      py       = frame_start ? sprite_y : pos_y;
      tgt_line = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
      row      = {1'b0, tgt_line} - {1'b0, py};
      row_ok   = !row[10] && (row < 11'(SPR_H));
      base     = ADDR_W'(row) * ADDR_W'(SPR_W);
   end

   // Fetch FSM next-state, address sequencing and buffer write control.
   always_comb begin
      state_n     = state;
      k_n         = k;
      addr_n      = rom_addr;
      busy_n      = busy;
      row_valid_n = row_valid;
      wr_en       = 1'b0;
      wr_idx      = '0;
      case (state)
         IDLE: begin
            if (fetch_start) begin
               row_valid_n = 1'b0;
               if (row_ok) begin
                  state_n = FETCH;
                  k_n     = '0;
                  addr_n  = base;
                  busy_n  = 1'b1;
               end
            end
         end
         FETCH: begin
            if (k != '0) begin
               wr_en  = 1'b1;
               wr_idx = IW'(k - KW'(1));
            end
            k_n = k + KW'(1);
            if (k == KW'(SPR_W - 1)) begin
               state_n = DRAIN;
            end else begin
               addr_n = rom_addr + ADDR_W'(1);
            end
         end
         DRAIN: begin
            wr_en       = 1'b1;
            wr_idx      = IW'(SPR_W - 1);
            busy_n      = 1'b0;
            row_valid_n = 1'b1;
            state_n     = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Fetch datapath registers and per-frame sprite position.
   always_ff @(posedge clk) begin
      if (reset) begin
         k         <= '0;
         rom_addr  <= '0;
         busy      <= 1'b0;
         row_valid <= 1'b0;
         pos_x     <= '0;
         pos_y     <= '0;
      end else begin
         k         <= k_n;
         rom_addr  <= addr_n;
         busy      <= busy_n;
         row_valid <= row_valid_n;
         if (frame_start) begin
            pos_x <= sprite_x;
            pos_y <= sprite_y;
         end
      end
   end

   // Line buffer write port; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) line_buf[wr_idx] <= rom_data;
   end

   // Horizontal hit test in 12 bits so pos_x+SPR_W cannot wrap.
   always_comb begin
      hx  = {1'b0, hcount};
      lo  = {1'b0, pos_x};
      hi  = lo + 12'(SPR_W);
      idx = IW'(hx - lo);
      px  = line_buf[idx];
      hit = row_valid && !busy && (hx >= lo) && (hx < hi) &&
            (hcount < 11'(H_ACTIVE));
   end

   // Registered pixel output, one cycle behind hcount.
   always_ff @(posedge clk) begin
      if (reset || !hit) begin
         pix_rgb   <= '0;
         pix_valid <= 1'b0;
      end else begin
         pix_rgb   <= px;
         pix_valid <= (px != TRANSP_KEY);
      end
   end

endmodule

// File: tb/tb_dino_sprite_line_fetcher.sv
// Bench for the sprite line fetcher: directed sequences, a pixel table
// and randomized fetch/display scenarios against a line-level model.
module tb_dino_sprite_line_fetcher;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        frame_start, fetch_start;
   logic [10:0] sprite_x;
   logic [9:0]  sprite_y;
   logic [11:0] rom_addr;
   logic [15:0] rom_data;
   logic [15:0] pix_rgb;
   logic        pix_valid, busy;

   logic [15:0] rom_mem [4096];

   int pass_cnt = 0;
   int total    = 0;

   typedef struct {
      logic [10:0] hc;
      logic [15:0] rgb;
      logic        vld;
      string       name;
   } vec_t;

   vec_t tbl [6];

   dino_sprite_line_fetcher dut (
      .clk         (clk),
      .reset       (reset),
      .hcount      (hcount),
      .vcount      (vcount),
      .frame_start (frame_start),
      .fetch_start (fetch_start),
      .sprite_x    (sprite_x),
      .sprite_y    (sprite_y),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .pix_rgb     (pix_rgb),
      .pix_valid   (pix_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Registered sprite ROM model.
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_frame(input int x, input int y);
      sprite_x    = 11'(x);
      sprite_y    = 10'(y);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic pix(input int hc, output logic [15:0] rgb,
                      output logic vld);
      hcount = 11'(hc);
      step();
      rgb = pix_rgb;
      vld = pix_valid;
   endtask

   // Issues fetch_start, then counts busy cycles and address errors.
   task automatic run_fetch(input int v, input int base, input int pulse_at,
                            input logic fs, output int n, output int bad);
      vcount      = 10'(v);
      frame_start = fs;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      frame_start = 1'b0;
      n   = 0;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (!busy) break;
         if (n < 64 && rom_addr !== 12'(base + n)) bad++;
         n++;
         if (n == pulse_at) begin
            fetch_start = 1'b1;
            vcount      = 10'd5;
         end
         step();
         fetch_start = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] rgb;
      logic        vld;
      int          n, bad;

      for (int a = 0; a < 4096; a++) rom_mem[a] = 16'(a);
      reset = 1'b1; hcount = '0; vcount = '0;
      frame_start = 1'b0; fetch_start = 1'b0;
      sprite_x = '0; sprite_y = '0;
      step();
      step();
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_rgb", 32'(pix_rgb), 32'd0);
      chk("rst_valid", 32'(pix_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step();

      // Row 0 fetch, then pixel table.
      do_frame(100, 50);
      run_fetch(49, 0, -1, 1'b0, n, bad);
      chk("t1_len", 32'(n), 32'd65);
      chk("t1_addr", 32'(bad), 32'd0);
      tbl[0] = '{11'd100, 16'h0000, 1'b1, "t1_h100"};
      tbl[1] = '{11'd163, 16'h003F, 1'b1, "t1_h163"};
      tbl[2] = '{11'd164, 16'h0000, 1'b0, "t1_h164"};
      tbl[3] = '{11'd99,  16'h0000, 1'b0, "t1_h99"};
      tbl[4] = '{11'd130, 16'h001E, 1'b1, "t1_h130"};
      tbl[5] = '{11'd700, 16'h0000, 1'b0, "t1_h700"};
      for (int i = 0; i < 6; i++) begin
         pix(int'(tbl[i].hc), rgb, vld);
         chk({tbl[i].name, "_rgb"}, 32'(rgb), 32'(tbl[i].rgb));
         chk({tbl[i].name, "_vld"}, 32'(vld), 32'(tbl[i].vld));
      end

      // Last row, then one past the sprite.
      run_fetch(80, 1984, -1, 1'b0, n, bad);
      chk("t2_len", 32'(n), 32'd65);
      chk("t2_addr", 32'(bad), 32'd0);
      pix(100, rgb, vld);
      chk("t2_rgb", 32'(rgb), 32'd1984);
      chk("t2_vld", 32'(vld), 32'd1);
      run_fetch(81, 0, -1, 1'b0, n, bad);
      chk("t2_nofetch", 32'(n), 32'd0);
      chk("t2_hold", 32'(rom_addr), 32'd2047);
      pix(100, rgb, vld);
      chk("t2_cleared", 32'(vld), 32'd0);

      // Transparent key.
      rom_mem[5] = 16'hFFFF;
      do_frame(0, 10);
      run_fetch(9, 0, -1, 1'b0, n, bad);
      chk("t3_len", 32'(n), 32'd65);
      pix(5, rgb, vld);
      chk("t3_key_vld", 32'(vld), 32'd0);
      chk("t3_key_rgb", 32'(rgb), 32'hFFFF);
      pix(4, rgb, vld);
      chk("t3_h4_vld", 32'(vld), 32'd1);
      rom_mem[5] = 16'd5;

      // Right-edge clipping.
      do_frame(620, 10);
      run_fetch(9, 0, -1, 1'b0, n, bad);
      bad = 0;
      for (int h = 620; h < 640; h++) begin
         pix(h, rgb, vld);
         if (rgb !== 16'(h - 620) || vld !== 1'b1) bad++;
      end
      chk("t4_visible", 32'(bad), 32'd0);
      pix(640, rgb, vld);
      chk("t4_h640", 32'({rgb, 7'd0, vld}), 32'd0);
      pix(660, rgb, vld);
      chk("t4_h660", 32'({rgb, 7'd0, vld}), 32'd0);

      // Frame wrap plus ignored fetch_start mid-fetch.
      do_frame(0, 0);
      run_fetch(524, 0, 10, 1'b0, n, bad);
      chk("t5_len", 32'(n), 32'd65);
      chk("t5_addr", 32'(bad), 32'd0);
      pix(3, rgb, vld);
      chk("t5_rgb", 32'(rgb), 32'd3);

      // Reset in the middle of a fetch.
      do_frame(100, 50);
      vcount = 10'd49; fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      repeat (19) step();
      reset = 1'b1;
      step();
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_addr", 32'(rom_addr), 32'd0);
      chk("t6_vld", 32'(pix_valid), 32'd0);
      reset = 1'b0;
      pix(0, rgb, vld);
      chk("t6_rowvalid", 32'(vld), 32'd0);
      run_fetch(2, 192, -1, 1'b0, n, bad);
      chk("t6_len", 32'(n), 32'd65);
      chk("t6_addr2", 32'(bad), 32'd0);
      pix(1, rgb, vld);
      chk("t6_rgb", 32'(rgb), 32'd193);

      // Randomized scenarios against a line-level model.
      for (int a = 0; a < 4096; a++)
         rom_mem[a] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      for (int it = 0; it < 25; it++) begin
         int   x, y, v, tl, r, base, hc, e;
         logic fs, inr, ins, ev;
         x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047)
                                         : $urandom_range(0, 700);
         y = $urandom_range(0, 523);
         if ($urandom_range(0, 3) != 0) begin
            tl = y + $urandom_range(0, 33) - 1;
            if (tl < 0) tl = 0;
            if (tl > 524) tl = 524;
            v = (tl == 0) ? 524 : tl - 1;
         end else begin
            v = $urandom_range(0, 524);
         end
         tl   = (v == 524) ? 0 : v + 1;
         r    = tl - y;
         inr  = (r >= 0 && r < 32);
         base = inr ? r * 64 : 0;
         fs   = 1'($urandom_range(0, 1));
         sprite_x = 11'(x);
         sprite_y = 10'(y);
         if (!fs) do_frame(x, y);
         run_fetch(v, base, -1, fs, n, bad);
         chk("rnd_len", 32'(n), inr ? 32'd65 : 32'd0);
         if (inr) chk("rnd_addr", 32'(bad), 32'd0);
         for (int j = 0; j < 6; j++) begin
            hc = ($urandom_range(0, 2) != 0) ? x + $urandom_range(0, 70) - 3
                                             : $urandom_range(0, 1023);
            if (hc < 0) hc = 0;
            if (hc > 2047) hc = 2047;
            ins = inr && hc >= x && hc < x + 64 && hc < 640;
            e   = ins ? int'(rom_mem[base + hc - x]) : 0;
            ev  = ins && e != 32'hFFFF;
            pix(hc, rgb, vld);
            chk("rnd_rgb", 32'(rgb), 32'(e));
            chk("rnd_vld", 32'(vld), 32'(ev));
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
